// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline defines: datapath select codes, pipeline-control FSM encoding,
// control-word layout and the memory-wait limit.
package pipe_ctrl_pkg;

    // Next-PC source select
    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JMP  = 2'd2;
    localparam logic [1:0] NPC_JR   = 2'd3;

    // ALU operand-B select
    localparam logic       ALUB_RS2 = 1'b0;
    localparam logic       ALUB_IMM = 1'b1;

    // Write-back source select
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;
    localparam logic [1:0] WB_IMM   = 2'd3;

    // DRAM access size
    localparam logic [1:0] DRAM_BYTE = 2'd0;
    localparam logic [1:0] DRAM_HALF = 2'd1;
    localparam logic [1:0] DRAM_WORD = 2'd2;

    localparam int unsigned WAIT_MAX_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_HOLD = 7'b000_0000;

    // Wait counter is never narrower than 8 bits.
    function automatic int unsigned wait_cnt_width(input int unsigned wmax);
        int unsigned w;
        w = $clog2(wmax + 1);
        return (w < 8) ? 8 : w;
    endfunction

    // Control word for a pipeline that is free to move; stall beats flush.
    function automatic pipe_ctrl_t run_ctrl(input logic stop, input logic flush);
        pipe_ctrl_t c;
        if (stop) begin
            c = 7'b001_1101;
        end else if (flush) begin
            c = 7'b111_1111;
        end else begin
            c = 7'b111_1100;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: step when requested unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stall/flush enables, DRAM wait handling with
// timeout, per-stage valid tracking and a stall-cycle statistic.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stop_req,
    input  logic        flush_req,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [3:0]  stage_vld,
    output logic [15:0] stall_cnt,
    output logic        mem_err
);

    localparam int unsigned      WCW      = wait_cnt_width(WAIT_MAX);
    localparam logic [WCW-1:0]   WAIT_LIM = WCW'(WAIT_MAX);
    localparam logic [WCW-1:0]   WAIT_ONE = {{(WCW-1){1'b0}}, 1'b1};

    pipe_state_e    state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]     stage_vld_q, stage_vld_d;
    logic           mem_err_q, mem_err_d;
    pipe_ctrl_t     ctrl_s;
    logic           stall_inc_s;

    // FSM next state, wait counter and Mealy control word
    always_comb begin
        ctrl_s     = CTRL_HOLD;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = {WCW{1'b0}};
                end else begin
                    ctrl_s = run_ctrl(stop_req, flush_req);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    ctrl_s  = run_ctrl(stop_req, flush_req);
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LIM) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            ST_ERR: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valid bits follow their stage register: flush clears, enable loads, else hold
    always_comb begin
        stage_vld_d = stage_vld_q;
        if (ctrl_s.ifid_flush) begin
            stage_vld_d[0] = 1'b0;
        end else if (ctrl_s.ifid_en) begin
            stage_vld_d[0] = 1'b1;
        end else begin
            stage_vld_d[0] = stage_vld_q[0];
        end
        if (ctrl_s.idex_flush) begin
            stage_vld_d[1] = 1'b0;
        end else if (ctrl_s.idex_en) begin
            stage_vld_d[1] = stage_vld_q[0];
        end else begin
            stage_vld_d[1] = stage_vld_q[1];
        end
        if (ctrl_s.exmem_en) begin
            stage_vld_d[2] = stage_vld_q[1];
        end else begin
            stage_vld_d[2] = stage_vld_q[2];
        end
        if (ctrl_s.memwb_en) begin
            stage_vld_d[3] = stage_vld_q[2];
        end else begin
            stage_vld_d[3] = stage_vld_q[3];
        end
    end

    // State, wait counter, valid bits and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= {WCW{1'b0}};
            stage_vld_q <= 4'b0000;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stage_vld_q <= stage_vld_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // ERR and IDLE freeze the PC too, but are not counted as pipeline stalls.
    assign stall_inc_s = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !ctrl_s.pc_en;

    sat_counter #(
        .WIDTH (16)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .cnt   (stall_cnt)
    );

    assign pc_en      = ctrl_s.pc_en;
    assign ifid_en    = ctrl_s.ifid_en;
    assign idex_en    = ctrl_s.idex_en;
    assign exmem_en   = ctrl_s.exmem_en;
    assign memwb_en   = ctrl_s.memwb_en;
    assign ifid_flush = ctrl_s.ifid_flush;
    assign idex_flush = ctrl_s.idex_flush;
    assign stage_vld  = stage_vld_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance for pipeline behaviour and
// saturation, a WAIT_MAX=4 instance for the memory timeout.
module tb_pipe_ctrl;

    localparam logic [6:0] C_ZERO  = 7'b000_0000;
    localparam logic [6:0] C_NORM  = 7'b111_1100;
    localparam logic [6:0] C_STOP  = 7'b001_1101;
    localparam logic [6:0] C_FLUSH = 7'b111_1111;

    logic clk;
    int   n_cmp;
    int   n_err;

    logic        rst_n_a, stop_a, flush_a, mreq_a, mack_a;
    logic        pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a, ifid_fl_a, idex_fl_a;
    logic [3:0]  vld_a;
    logic [15:0] stall_a;
    logic        err_a;
    logic [6:0]  ctrl_a;

    logic        rst_n_b, stop_b, flush_b, mreq_b, mack_b;
    logic        pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b, ifid_fl_b, idex_fl_b;
    logic [3:0]  vld_b;
    logic [15:0] stall_b;
    logic        err_b;
    logic [6:0]  ctrl_b;

    assign ctrl_a = {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a, ifid_fl_a, idex_fl_a};
    assign ctrl_b = {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b, ifid_fl_b, idex_fl_b};

    pipe_ctrl dut_a (
        .clk(clk), .rst_n(rst_n_a), .stop_req(stop_a), .flush_req(flush_a),
        .mem_req(mreq_a), .mem_ack(mack_a),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a),
        .exmem_en(exmem_en_a), .memwb_en(memwb_en_a),
        .ifid_flush(ifid_fl_a), .idex_flush(idex_fl_a),
        .stage_vld(vld_a), .stall_cnt(stall_a), .mem_err(err_a)
    );

    pipe_ctrl #(.WAIT_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .stop_req(stop_b), .flush_req(flush_b),
        .mem_req(mreq_b), .mem_ack(mack_b),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b),
        .exmem_en(exmem_en_b), .memwb_en(memwb_en_b),
        .ifid_flush(ifid_fl_b), .idex_flush(idex_fl_b),
        .stage_vld(vld_b), .stall_cnt(stall_b), .mem_err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle later, just past the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] fill_exp [4];
        fill_exp[0] = 4'b0001; fill_exp[1] = 4'b0011;
        fill_exp[2] = 4'b0111; fill_exp[3] = 4'b1111;
        n_cmp = 0;
        n_err = 0;
        rst_n_a = 1'b0; stop_a = 1'b0; flush_a = 1'b0; mreq_a = 1'b0; mack_a = 1'b0;
        rst_n_b = 1'b0; stop_b = 1'b0; flush_b = 1'b0; mreq_b = 1'b0; mack_b = 1'b0;
        repeat (2) cyc();
        #3;
        check_eq("rst_vld", {28'd0, vld_a}, 32'h0);
        check_eq("rst_stall", {16'd0, stall_a}, 32'h0);
        check_eq("rst_err", {31'd0, err_a}, 32'h0);
        check_eq("rst_ctrl", {25'd0, ctrl_a}, {25'd0, C_ZERO});

        // Reset release: IDLE cycle then fill
        rst_n_a = 1'b1;
        #1;
        check_eq("idle_ctrl", {25'd0, ctrl_a}, {25'd0, C_ZERO});
        cyc(); #3;
        check_eq("run_ctrl", {25'd0, ctrl_a}, {25'd0, C_NORM});
        check_eq("run_vld0", {28'd0, vld_a}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(); #3;
            check_eq("fill_vld", {28'd0, vld_a}, {28'd0, fill_exp[i]});
        end
        check_eq("fill_stall", {16'd0, stall_a}, 32'h0);

        // Single load-use stall
        stop_a = 1'b1;
        #1;
        check_eq("stop_ctrl", {25'd0, ctrl_a}, {25'd0, C_STOP});
        cyc(); stop_a = 1'b0; #3;
        check_eq("stop_vld", {28'd0, vld_a}, 32'hD);
        check_eq("stop_stall", {16'd0, stall_a}, 32'd1);
        check_eq("post_stop_ctrl", {25'd0, ctrl_a}, {25'd0, C_NORM});

        // Stall and flush together: stall wins; then flush alone
        stop_a = 1'b1; flush_a = 1'b1;
        #1;
        check_eq("stopfl_ctrl", {25'd0, ctrl_a}, {25'd0, C_STOP});
        cyc(); stop_a = 1'b0; #3;
        check_eq("stopfl_vld", {28'd0, vld_a}, 32'h9);
        check_eq("stopfl_stall", {16'd0, stall_a}, 32'd2);
        check_eq("flush_ctrl", {25'd0, ctrl_a}, {25'd0, C_FLUSH});
        cyc(); flush_a = 1'b0; #3;
        check_eq("flush_vld", {28'd0, vld_a}, 32'h0);
        check_eq("flush_stall", {16'd0, stall_a}, 32'd2);
        repeat (4) cyc();
        #3;
        check_eq("refill_vld", {28'd0, vld_a}, 32'hF);

        // Memory wait: RUN entry + 5 waiting cycles, then ack
        mreq_a = 1'b1;
        #1;
        check_eq("mem_entry_ctrl", {25'd0, ctrl_a}, {25'd0, C_ZERO});
        cyc(); #3;
        check_eq("mem_w1_stall", {16'd0, stall_a}, 32'd3);
        check_eq("mem_w1_ctrl", {25'd0, ctrl_a}, {25'd0, C_ZERO});
        for (int i = 0; i < 4; i++) begin
            cyc(); #3;
            check_eq("mem_w_ctrl", {25'd0, ctrl_a}, {25'd0, C_ZERO});
            check_eq("mem_w_stall", {16'd0, stall_a}, 32'd4 + 32'(i));
            check_eq("mem_w_vld", {28'd0, vld_a}, 32'hF);
        end
        cyc();
        mack_a = 1'b1;
        #3;
        check_eq("mem_ack_ctrl", {25'd0, ctrl_a}, {25'd0, C_NORM});
        cyc(); mreq_a = 1'b0; mack_a = 1'b0; #3;
        check_eq("mem_done_stall", {16'd0, stall_a}, 32'd8);
        check_eq("mem_done_ctrl", {25'd0, ctrl_a}, {25'd0, C_NORM});
        check_eq("mem_done_err", {31'd0, err_a}, 32'h0);

        // Saturation of stall counter (currently 8)
        stop_a = 1'b1;
        repeat (65526) cyc();
        #3;
        check_eq("sat_fffe", {16'd0, stall_a}, 32'hFFFE);
        cyc(); #3;
        check_eq("sat_ffff", {16'd0, stall_a}, 32'hFFFF);
        cyc(); #3;
        check_eq("sat_hold", {16'd0, stall_a}, 32'hFFFF);

        // Asynchronous reset mid-cycle
        cyc();
        #1;
        rst_n_a = 1'b0;
        #1;
        check_eq("arst_stall", {16'd0, stall_a}, 32'h0);
        check_eq("arst_vld", {28'd0, vld_a}, 32'h0);
        check_eq("arst_ctrl", {25'd0, ctrl_a}, {25'd0, C_ZERO});
        stop_a = 1'b0;
        rst_n_a = 1'b1;

        // Timeout on the WAIT_MAX=4 instance
        rst_n_b = 1'b1;
        cyc();
        mreq_b = 1'b1;
        #3;
        check_eq("to_entry_ctrl", {25'd0, ctrl_b}, {25'd0, C_ZERO});
        cyc(); #3;
        for (int i = 0; i < 4; i++) begin
            cyc(); #3;
            check_eq("to_wait_err", {31'd0, err_b}, 32'h0);
            check_eq("to_wait_ctrl", {25'd0, ctrl_b}, {25'd0, C_ZERO});
        end
        cyc(); #3;
        check_eq("to_err", {31'd0, err_b}, 32'h1);
        check_eq("to_stall", {16'd0, stall_b}, 32'd6);
        mack_b = 1'b1;
        #1;
        check_eq("err_ack_ctrl", {25'd0, ctrl_b}, {25'd0, C_ZERO});
        repeat (3) cyc();
        #3;
        check_eq("err_sticky", {31'd0, err_b}, 32'h1);
        check_eq("err_stall_hold", {16'd0, stall_b}, 32'd6);
        #1;
        rst_n_b = 1'b0;
        #1;
        check_eq("err_arst_err", {31'd0, err_b}, 32'h0);
        check_eq("err_arst_stall", {16'd0, stall_b}, 32'h0);
        check_eq("err_arst_ctrl", {25'd0, ctrl_b}, {25'd0, C_ZERO});
        mreq_b = 1'b0; mack_b = 1'b0;
        rst_n_b = 1'b1;
        cyc(); #3;
        check_eq("rerun_ctrl", {25'd0, ctrl_b}, {25'd0, C_NORM});
        check_eq("rerun_err", {31'd0, err_b}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: WAIT_MAX, default 255, maximum memory-wait cycles before the error state is entered.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 stop_req  in  1  load-use stall request from hazard detection (ID stage).
REQ-005 flush_req  in  1  taken jump/branch flush request (ID stage).
REQ-006 mem_req  in  1  EX/MEM holds a valid DRAM access.
REQ-007 mem_ack  in  1  DRAM access completes this cycle.
REQ-008 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
REQ-009 ifid_flush, idex_flush  out  1 each  synchronous clear (bubble insert) of IF/ID and ID/EX.
REQ-010 stage_vld  out  4  valid bits: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB.
REQ-011 stall_cnt  out  16  saturating count of cycles with pc_en=0 while in RUN or MEM_WAIT.
REQ-012 mem_err  out  1  sticky memory-timeout flag.

Function
REQ-013 FSM states: IDLE, RUN, MEM_WAIT, ERR; IDLE is the reset state.
REQ-014 IDLE: all enables 0, flushes 0; next cycle -> RUN unconditionally.
REQ-015 RUN, mem_req=1 and mem_ack=0: all enables 0, flushes 0; -> MEM_WAIT.
REQ-016 RUN, no memory wait, stop_req=1: pc_en=0, ifid_en=0, idex_flush=1, idex_en/exmem_en/memwb_en=1, ifid_flush=0; flush_req ignored that cycle.
REQ-017 RUN, no memory wait, stop_req=0, flush_req=1: all enables 1, ifid_flush=1, idex_flush=1.
REQ-018 RUN, no memory wait, no stop/flush: all enables 1, flushes 0.
REQ-019 MEM_WAIT, mem_ack=0: all enables 0, flushes 0; wait counter increments.
REQ-020 MEM_WAIT, mem_ack=1: outputs as RUN per REQ-016..018 in the same cycle; -> RUN.
REQ-021 Wait counter (8-bit minimum, wide enough for WAIT_MAX) clears on entry to MEM_WAIT; when it equals WAIT_MAX with mem_ack=0 -> ERR.
REQ-022 ERR: all enables 0, flushes 0, mem_err=1; remains until reset.
REQ-023 stage_vld update only on edges where the corresponding enable or flush is active; flush forces the bit to 0; otherwise held.
REQ-024 Advancing stage: stage_vld[0]<=1, [1]<=[0], [2]<=[1], [3]<=[2]; stop bubble: [1]<=0, [0] held, [3:2] advance.
REQ-025 stall_cnt increments once per cycle with pc_en=0 in RUN or MEM_WAIT, saturates at 16'hFFFF, never wraps.
REQ-026 All outputs are a function of current state and inputs only (Mealy outputs); no output depends on a registered copy of stop_req/flush_req.

Reset
REQ-027 rst_n=0 asynchronously forces state=IDLE, stage_vld=4'b0000, stall_cnt=0, wait counter=0, mem_err=0.
REQ-028 Reset asserted mid MEM_WAIT or ERR abandons the access; outputs take the IDLE values immediately, independent of clk.

Structure
REQ-029 FSM state encoding and WAIT_MAX default reside in the shared defines package alongside the existing NPC/ALUB/WB/DRAM constants.
REQ-030 The 16-bit saturating counter is a sub-module sat_counter, parameterised by width; no other sub-modules.

Verification
REQ-031 Reset release -> one IDLE cycle with pc_en=0, then RUN with all enables 1, stage_vld fills 0001,0011,0111,1111 over four cycles.
REQ-032 stop_req=1 for one cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1, stage_vld[1]=0 next cycle, stall_cnt=1.
REQ-033 stop_req=1 and flush_req=1 together -> stop behaviour only, ifid_flush=0; flush_req alone next cycle -> ifid_flush=idex_flush=1, stage_vld[1:0]=00.
REQ-034 mem_req=1, mem_ack low 5 cycles then high -> 6 cycles pc_en=0 (RUN entry plus 5 MEM_WAIT), enables 1 on ack cycle, stall_cnt=6.
REQ-035 mem_req=1, mem_ack never asserted, WAIT_MAX=4 -> ERR after the wait counter reaches 4, mem_err=1 held; rst_n pulse clears to IDLE asynchronously.
REQ-036 stall_cnt preloaded by 65535 stall cycles, one more stall -> stall_cnt stays 16'hFFFF.
